// File: rtl/mem_resp_demux.sv
// mem_resp_demux: routes in-order memory read responses to fetch (A) or load/store (B)
// using a 1-bit source tag FIFO recorded at request acceptance.
module mem_resp_demux #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_fire,
  input  logic                       req_src,
  output logic                       req_ready,
  input  logic                       mem_rvalid,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       mem_rready,
  output logic                       a_valid,
  output logic [DATA_W-1:0]          a_data,
  input  logic                       a_ready,
  output logic                       b_valid,
  output logic [DATA_W-1:0]          b_data,
  input  logic                       b_ready,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] tags_q;
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             empty, full, head, push, pop;
  always_comb begin
    empty       = (cnt_q == '0);
    full        = (cnt_q == CW'(DEPTH));
    head        = tags_q[rd_q];
    req_ready   = !full;
    a_data      = mem_rdata;
    b_data      = mem_rdata;
    a_valid     = mem_rvalid && !empty && !head;
    b_valid     = mem_rvalid && !empty && head;
    // with no tag held, responses are strays: accept and drop them
    mem_rready  = empty ? 1'b1 : (head ? b_ready : a_ready);
    push        = req_fire && !full;
    pop         = mem_rvalid && mem_rready && !empty;
    cnt_d       = (push && !pop) ? cnt_q + CW'(1) : (pop && !push) ? cnt_q - CW'(1) : cnt_q;
    err_d       = err_q || (req_fire && full) || (mem_rvalid && empty);
    outstanding = cnt_q;
    err         = err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      tags_q <= '0;
    end else begin
      if (push) tags_q[wr_q] <= req_src;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: doc/mem_resp_demux.md
# mem_resp_demux

Response-side router of the shared memory port: fetch and data requests are merged onto one memory request channel, and this block steers each returning read response back to the unit that issued it. It records the source of every accepted request in an in-order tag FIFO. It pops one tag per response. It routes response data to port A (instruction fetch) or port B (load/store) with valid/ready handshakes. It sits between the memory read-data channel and the two requesters, alongside the request merge mux.

## Interface
- DATA_W, 32, width of response data
- DEPTH, 4, max outstanding requests (power of two, ≥2)

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_fire  in  1  a request was accepted by memory this cycle
- req_src  in  1  source of that request: 0 = port A, 1 = port B
- req_ready  out  1  tag FIFO can record a request; upstream merge mux issues only when high
- mem_rvalid  in  1  memory response valid
- mem_rdata  in  DATA_W  memory response data
- mem_rready  out  1  response accepted
- a_valid / a_data / a_ready  out / out DATA_W / in  response channel to fetch
- b_valid / b_data / b_ready  out / out DATA_W / in  response channel to load/store
- outstanding  out  $clog2(DEPTH+1)  number of tags held
- err  out  1  sticky protocol-violation flag

## Operation
- Tag FIFO: DEPTH entries of 1 bit, with write pointer, read pointer and occupancy count. Pointers wrap modulo DEPTH.
- Push: on req_fire && req_ready, write req_src at the write pointer. The write pointer increments.
- req_ready = (outstanding != DEPTH). It is based on occupancy only. A pop in the same cycle does not free a slot for a push in that cycle.
- Head tag = entry at the read pointer when outstanding != 0.
- Routing (combinational) when outstanding != 0:
  - head = 0: a_valid = mem_rvalid, a_data = mem_rdata, mem_rready = a_ready, b_valid = 0.
  - head = 1: the same, mirrored onto port B.
- a_data and b_data are driven with mem_rdata at all times. Only the valid signals gate them.
- Pop: on mem_rvalid && mem_rready with outstanding != 0. The read pointer increments.
- Occupancy: push only → +1, pop only → −1, push and pop together → unchanged.
- No bypass. A tag pushed in cycle N is usable for routing from cycle N+1.
- Stray response (outstanding == 0 and mem_rvalid):
  - mem_rready = 1 and the response is dropped.
  - a_valid = b_valid = 0.
  - err is set.
- Overflow (req_fire while req_ready == 0): the push is ignored, pointers and count are unchanged, and err is set.
- err stays at 1 until rst.
- Reset values: both pointers = 0, outstanding = 0, err = 0.
- Output values in reset: req_ready = 1, mem_rready = 1, a_valid = 0, b_valid = 0.

## Timing
- Response path latency is zero cycles. mem_rvalid → a_valid/b_valid and a_ready/b_ready → mem_rready are purely combinational.
- Registered state: FIFO storage, pointers, count and err.
- outstanding, req_ready and err change only on a clock edge.
- Handshake on A and B: a transfer happens on valid && ready. A stalled response holds mem_rvalid and mem_rdata stable, because memory does not see mem_rready.
- Responses are strictly in order. A blocked head stalls every later response, including those for the other port.
- rst asserted mid-operation: all tags are discarded on that edge. From the next cycle the block is empty and any response that arrives is handled as stray.

## Test plan
- Basic routing:
  - Stimulus: after reset, push src 0 then src 1 in cycles 1 and 2. Memory returns 0x11111111 then 0x22222222 with a_ready = b_ready = 1.
  - Required response: A receives 0x11111111, then B receives 0x22222222. outstanding goes 1, 2, 1, 0. err = 0.
- Full:
  - Stimulus: push 4 tags with no responses.
  - Required response: req_ready = 0 with outstanding = 4. A 5th req_fire sets err = 1 and outstanding stays 4. Popping one restores req_ready = 1 the cycle after the pop.
- Backpressure:
  - Stimulus: head tag = 1, mem_rvalid = 1, b_ready = 0 for 3 cycles, then 1.
  - Required response: mem_rready = 0 for 3 cycles. The pop happens on the 4th cycle. a_valid stays 0 throughout.
- Simultaneous push and pop:
  - Stimulus: outstanding = 2, and in the same cycle req_fire and the response handshake.
  - Required response: outstanding stays 2. Tag order is preserved, checked by routing the next 2 responses.
- Wrap-around:
  - Stimulus: 10 alternating src 0/1 requests interleaved with responses, so the pointers wrap past DEPTH.
  - Required response: every response lands on the correct port in order.
- Stray and reset:
  - Stimulus (stray): mem_rvalid with outstanding = 0. Required response: mem_rready = 1, no valid on A or B, err = 1.
  - Stimulus (reset): rst with 3 tags held. Required response: outstanding = 0, err = 0, req_ready = 1 on the next cycle.
